// File: rtl/input_conditioner.sv
// input_conditioner: per-channel pad synchroniser, polarity normalisation, debounce,
// press/release/click strobes and long-press detection for asynchronous board inputs
module input_conditioner #(
    parameter int                  CHANNELS          = 6,
    parameter int                  SYNC_STAGES       = 2,
    parameter int                  DEBOUNCE_CYCLES   = 250000,
    parameter int                  LONG_PRESS_CYCLES = 25000000,
    parameter logic [CHANNELS-1:0] ACTIVE_LOW        = '0
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [CHANNELS-1:0] i_raw,
    output logic [CHANNELS-1:0] o_level,
    output logic [CHANNELS-1:0] o_press_stb,
    output logic [CHANNELS-1:0] o_release_stb,
    output logic [CHANNELS-1:0] o_click_stb,
    output logic [CHANNELS-1:0] o_long_stb,
    output logic [CHANNELS-1:0] o_held
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = (LONG_PRESS_CYCLES > 0) ? $clog2(LONG_PRESS_CYCLES + 1) : 1;
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] LP_MAX  = HW'(LONG_PRESS_CYCLES);
    localparam logic [HW-1:0] LP_LAST = HW'(LONG_PRESS_CYCLES - 1);
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic [DW-1:0]          db_cnt;
        logic [HW-1:0]          hold_cnt;
        logic                   level, press_q, rel_q, click_q, long_q, held_q;
        logic                   n, accept, rise, fall, reach;
        // a release on the same edge the hold would complete wins over the long-press
        always_comb begin
            n      = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW[c];
            accept = (n != level) && (db_cnt == DB_LAST);
            rise   = accept && n;
            fall   = accept && !n;
            reach  = (LONG_PRESS_CYCLES > 0) && level && !fall && (hold_cnt == LP_LAST);
        end
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                sync_q   <= {SYNC_STAGES{ACTIVE_LOW[c]}};
                db_cnt   <= '0;
                hold_cnt <= '0;
                level    <= 1'b0;
                press_q  <= 1'b0;
                rel_q    <= 1'b0;
                click_q  <= 1'b0;
                long_q   <= 1'b0;
                held_q   <= 1'b0;
            end else begin
                sync_q   <= {sync_q[SYNC_STAGES-2:0], i_raw[c]};
                db_cnt   <= (n == level || accept) ? '0 : db_cnt + DW'(1);
                level    <= accept ? n : level;
                press_q  <= rise;
                rel_q    <= fall;
                click_q  <= fall && !held_q;
                long_q   <= reach;
                held_q   <= fall ? 1'b0 : (reach ? 1'b1 : held_q);
                hold_cnt <= !level ? '0 : (hold_cnt == LP_MAX ? hold_cnt : hold_cnt + HW'(1));
            end
        end
        assign o_level[c]       = level;
        assign o_press_stb[c]   = press_q;
        assign o_release_stb[c] = rel_q;
        assign o_click_stb[c]   = click_q;
        assign o_long_stb[c]    = long_q;
        assign o_held[c]        = held_q;
    end
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed scenarios plus random pad activity, checked each cycle
// against a history-window reference model of the conditioner.
module tb_input_conditioner;
    localparam int CH = 2;
    localparam int S  = 2;
    localparam int D  = 4;
    localparam int L  = 10;
    localparam logic [CH-1:0] AL = 2'b01;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic [CH-1:0] i_raw = AL;
    logic [CH-1:0] o_level, o_press_stb, o_release_stb, o_click_stb, o_long_stb, o_held;
    int vectors = 0;
    int miscompares = 0;

    input_conditioner #(
        .CHANNELS(CH), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D),
        .LONG_PRESS_CYCLES(L), .ACTIVE_LOW(AL)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_raw(i_raw),
        .o_level(o_level), .o_press_stb(o_press_stb), .o_release_stb(o_release_stb),
        .o_click_stb(o_click_stb), .o_long_stb(o_long_stb), .o_held(o_held)
    );

    always #5 i_clk = ~i_clk;

    // Model: pad samples delayed S edges, level flips once the last D normalised
    // samples all disagree with it, strobes derived from the level history.
    logic [CH-1:0] syncq[$];
    logic [CH-1:0] nwin[$];
    logic [CH-1:0] m_level, m_press, m_rel, m_click, m_long, m_held;
    int            run[CH];
    logic [6*CH-1:0] dut_v, exp_v;
    assign dut_v = {o_level, o_press_stb, o_release_stb, o_click_stb, o_long_stb, o_held};
    assign exp_v = {m_level, m_press, m_rel, m_click, m_long, m_held};

    task automatic model_reset();
        syncq = {};
        nwin  = {};
        for (int i = 0; i < S; i++) syncq.push_back(AL);
        for (int i = 0; i < D; i++) nwin.push_back('0);
        {m_level, m_press, m_rel, m_click, m_long, m_held} = '0;
        for (int c = 0; c < CH; c++) run[c] = 0;
    endtask

    task automatic model_edge(input logic [CH-1:0] r);
        logic [CH-1:0] nl;
        bit flip;
        nwin.push_back(syncq[0] ^ AL);
        void'(nwin.pop_front());
        syncq.push_back(r);
        void'(syncq.pop_front());
        nl = m_level;
        for (int c = 0; c < CH; c++) begin
            flip = 1'b1;
            foreach (nwin[k]) if (nwin[k][c] == m_level[c]) flip = 1'b0;
            if (flip) nl[c] = ~m_level[c];
        end
        m_press = nl & ~m_level;
        m_rel   = m_level & ~nl;
        m_click = m_rel & ~m_held;
        for (int c = 0; c < CH; c++) begin
            run[c]    = nl[c] ? run[c] + 1 : 0;
            m_long[c] = (L > 0) && nl[c] && (run[c] == L + 1);
            m_held[c] = (L > 0) && nl[c] && (run[c] >= L + 1);
        end
        m_level = nl;
    endtask

    task automatic step(input logic [CH-1:0] r);
        i_raw = r;
        @(posedge i_clk);
        if (i_rst_n) model_edge(r);
        @(negedge i_clk);
    endtask

    task automatic test_reset();
        i_raw = AL;
        i_rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge i_clk);
        vectors++;
        if (dut_v !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h want 0", dut_v);
        end
        i_rst_n = 1'b1;
        repeat (20) begin
            step(AL);
            vectors++;
            if (dut_v !== exp_v || dut_v !== '0) begin
                miscompares++;
                $display("FAIL reset_idle: got %h want %h", dut_v, exp_v);
            end
        end
    endtask

    task automatic test_press();
        int seen;
        seen = 0;
        for (int k = 1; k <= 12; k++) begin
            step(2'b11);
            vectors++;
            if (dut_v !== exp_v) begin
                miscompares++;
                $display("FAIL press_model: got %h want %h", dut_v, exp_v);
            end
            if (o_press_stb[1] && seen == 0) seen = k;
        end
        vectors++;
        if (seen != 6) begin
            miscompares++;
            $display("FAIL press_latency: got %0d want 6", seen);
        end
        repeat (10) begin
            step(AL);
            vectors++;
            if (dut_v !== exp_v) begin
                miscompares++;
                $display("FAIL press_release_model: got %h want %h", dut_v, exp_v);
            end
        end
    endtask

    task automatic test_bounce();
        logic [CH-1:0] pat[4];
        int n_press, at;
        pat = '{2'b11, 2'b01, 2'b11, 2'b01};
        n_press = 0;
        at = 0;
        for (int k = 0; k < 4; k++) begin
            step(pat[k]);
            vectors++;
            if (dut_v !== exp_v) begin
                miscompares++;
                $display("FAIL bounce_model: got %h want %h", dut_v, exp_v);
            end
            if (o_press_stb[1]) n_press++;
        end
        for (int k = 1; k <= 12; k++) begin
            step(2'b11);
            vectors++;
            if (dut_v !== exp_v) begin
                miscompares++;
                $display("FAIL bounce_stable_model: got %h want %h", dut_v, exp_v);
            end
            if (o_press_stb[1]) begin
                n_press++;
                at = k;
            end
        end
        vectors++;
        if (n_press != 1 || at != 6) begin
            miscompares++;
            $display("FAIL bounce_single_press: got count %0d at %0d want count 1 at 6", n_press, at);
        end
        repeat (10) step(AL);
    endtask

    task automatic test_long_press();
        int tp, tl, k;
        bit rel_seen;
        tp = -1;
        tl = -1;
        rel_seen = 1'b0;
        for (k = 1; k <= 40 && !(tp > 0 && k > tp + 12); k++) begin
            step(2'b00);
            vectors++;
            if (dut_v !== exp_v) begin
                miscompares++;
                $display("FAIL long_model: got %h want %h", dut_v, exp_v);
            end
            if (o_press_stb[0]) tp = k;
            if (o_long_stb[0]) tl = k;
        end
        vectors++;
        if (tp < 0 || tl - tp != 10 || o_held[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL long_timing: got press %0d long %0d held %b want long=press+10 held 1", tp, tl, o_held[0]);
        end
        for (int j = 0; j < 12; j++) begin
            step(AL);
            vectors++;
            if (dut_v !== exp_v) begin
                miscompares++;
                $display("FAIL long_release_model: got %h want %h", dut_v, exp_v);
            end
            if (o_release_stb[0]) begin
                rel_seen = 1'b1;
                vectors++;
                if (o_click_stb[0] !== 1'b0 || o_held[0] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL long_no_click: got click %b held %b want 0 0", o_click_stb[0], o_held[0]);
                end
            end
        end
        vectors++;
        if (!rel_seen) begin
            miscompares++;
            $display("FAIL long_release_seen: got none want one release");
        end
    endtask

    task automatic test_short_click();
        int hi_cycles;
        bit click_ok;
        hi_cycles = 0;
        click_ok = 1'b0;
        repeat (8) step(2'b00);
        for (int k = 0; k < 17; k++) begin
            step(k < 5 ? 2'b10 : 2'b00);
            vectors++;
            if (dut_v !== exp_v) begin
                miscompares++;
                $display("FAIL click_model: got %h want %h", dut_v, exp_v);
            end
            if (o_level[1]) hi_cycles++;
            if (o_release_stb[1]) click_ok = o_click_stb[1] && o_level[0];
        end
        vectors++;
        if (!click_ok || hi_cycles != 5) begin
            miscompares++;
            $display("FAIL short_click: got click_ok %b high %0d want 1 and 5", click_ok, hi_cycles);
        end
        repeat (10) step(AL);
    endtask

    task automatic test_reset_mid_press();
        int tp, tl;
        bit bad_rel;
        tp = -1;
        tl = -1;
        bad_rel = 1'b0;
        for (int k = 0; k < 30 && !o_held[0]; k++) step(2'b00);
        vectors++;
        if (o_held[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_setup: got held %b want 1", o_held[0]);
        end
        i_rst_n = 1'b0;
        model_reset();
        #1;
        vectors++;
        if (dut_v !== '0) begin
            miscompares++;
            $display("FAIL midreset_clear: got %h want 0", dut_v);
        end
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            step(2'b00);
            vectors++;
            if (dut_v !== exp_v) begin
                miscompares++;
                $display("FAIL midreset_model: got %h want %h", dut_v, exp_v);
            end
            if (o_release_stb[0] || o_click_stb[0]) bad_rel = 1'b1;
            if (o_press_stb[0]) tp = k;
            if (o_long_stb[0]) tl = k;
        end
        vectors++;
        if (bad_rel || tp != 6 || tl != 16) begin
            miscompares++;
            $display("FAIL midreset_repress: got rel %b press %0d long %0d want 0 6 16", bad_rel, tp, tl);
        end
        repeat (12) step(AL);
    endtask

    task automatic test_random();
        logic [CH-1:0] r;
        r = AL;
        for (int k = 0; k < 3000; k++) begin
            for (int c = 0; c < CH; c++)
                if ($urandom_range(0, k < 1500 ? 5 : 19) == 0) r[c] = ~r[c];
            if (k == 1500) begin
                i_rst_n = 1'b0;
                model_reset();
                @(negedge i_clk);
                vectors++;
                if (dut_v !== '0) begin
                    miscompares++;
                    $display("FAIL random_reset: got %h want 0", dut_v);
                end
                i_rst_n = 1'b1;
            end
            step(r);
            vectors++;
            if (dut_v !== exp_v) begin
                miscompares++;
                $display("FAIL random_model: cycle %0d got %h want %h", k, dut_v, exp_v);
            end
        end
    endtask

    initial begin
        model_reset();
        @(negedge i_clk);
        test_reset();
        test_press();
        test_bounce();
        test_long_press();
        test_short_click();
        test_reset_mid_press();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
